// File: rtl/yc_noc_arb.sv
// Packet-aware round-robin arbiter/mux feeding the NoC skid stage through a
// one-entry output register; grants are held per packet and over-length packets are cut.
module yc_noc_arb #(
    parameter  int N         = 4,
    parameter  int W         = 32,
    parameter  int MAX_FLITS = 16,
    localparam int SW        = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   s_valid,
    input  logic [N*W-1:0] s_data,
    input  logic [N-1:0]   s_last,
    output logic [N-1:0]   s_ready,
    output logic           m_valid,
    output logic [W-1:0]   m_data,
    output logic           m_last,
    output logic [SW-1:0]  m_src,
    input  logic           m_ready,
    output logic           busy,
    output logic           err_overlen
);

    localparam int              CW       = $clog2(MAX_FLITS + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(MAX_FLITS - 1);
    localparam logic [SW-1:0]   IDX_LAST = SW'(N - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          state_r;
    logic [SW-1:0]   rr_ptr_r;
    logic [SW-1:0]   owner_r;
    logic [CW-1:0]   flit_cnt_r;
    logic            out_full_r;
    logic [W-1:0]    m_data_r;
    logic            m_last_r;
    logic [SW-1:0]   m_src_r;
    logic            err_r;

    logic [SW-1:0]   grant_s;
    logic            grant_vld_s;
    logic [SW:0]     sum_s;
    logic [SW-1:0]   cand_s;
    logic [W-1:0]    sel_data_s;
    logic [N-1:0]    s_ready_s;
    logic            out_acc_s;
    logic            accept_s;
    logic            drain_s;
    logic            force_s;
    logic            eff_last_s;

    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] idx);
        if (idx == IDX_LAST) begin
            return {SW{1'b0}};
        end else begin
            return idx + SW'(1);
        end
    endfunction

    // Grant selection: owner while locked, otherwise first valid source at or after rr_ptr.
    // The scan runs from the farthest offset down so the nearest valid source wins.
    always_comb begin
        grant_s     = {SW{1'b0}};
        grant_vld_s = 1'b0;
        sum_s       = {(SW+1){1'b0}};
        cand_s      = {SW{1'b0}};
        if (state_r == ST_LOCK) begin
            grant_s     = owner_r;
            grant_vld_s = s_valid[owner_r];
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                sum_s = {1'b0, rr_ptr_r} + (SW+1)'(k);
                if (sum_s >= (SW+1)'(N)) begin
                    cand_s = SW'(sum_s - (SW+1)'(N));
                end else begin
                    cand_s = SW'(sum_s);
                end
                grant_s     = s_valid[cand_s] ? cand_s : grant_s;
                grant_vld_s = grant_vld_s | s_valid[cand_s];
            end
        end
    end

    // Data mux for the granted source.
    always_comb begin
        sel_data_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            sel_data_s = (grant_s == SW'(i)) ? s_data[i*W +: W] : sel_data_s;
        end
    end

    assign out_acc_s  = !out_full_r || m_ready;
    assign accept_s   = out_acc_s && grant_vld_s;
    assign drain_s    = out_full_r && m_ready;
    assign force_s    = (flit_cnt_r == CNT_LAST) && !s_last[grant_s];
    assign eff_last_s = s_last[grant_s] || force_s;

    // One-hot accept toward the granted source only.
    always_comb begin
        s_ready_s = {N{1'b0}};
        if (accept_s) begin
            s_ready_s[grant_s] = 1'b1;
        end else begin
            s_ready_s = {N{1'b0}};
        end
    end

    // One-entry output register: load on accept, empty on drain without reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_full_r <= 1'b0;
            m_data_r   <= {W{1'b0}};
            m_last_r   <= 1'b0;
            m_src_r    <= {SW{1'b0}};
        end else if (accept_s) begin
            out_full_r <= 1'b1;
            m_data_r   <= sel_data_s;
            m_last_r   <= eff_last_s;
            m_src_r    <= grant_s;
        end else if (drain_s) begin
            out_full_r <= 1'b0;
        end
    end

    // Packet FSM: lock onto a source until its effective last flit, then advance rr_ptr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= {SW{1'b0}};
            owner_r    <= {SW{1'b0}};
            flit_cnt_r <= {CW{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (accept_s && force_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (eff_last_s) begin
                            rr_ptr_r   <= next_idx(grant_s);
                            flit_cnt_r <= {CW{1'b0}};
                        end else begin
                            state_r    <= ST_LOCK;
                            owner_r    <= grant_s;
                            flit_cnt_r <= CW'(1);
                        end
                    end
                end
                ST_LOCK: begin
                    if (accept_s) begin
                        if (eff_last_s) begin
                            state_r    <= ST_IDLE;
                            rr_ptr_r   <= next_idx(owner_r);
                            flit_cnt_r <= {CW{1'b0}};
                        end else begin
                            flit_cnt_r <= flit_cnt_r + CW'(1);
                        end
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    flit_cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign s_ready     = s_ready_s;
    assign m_valid     = out_full_r;
    assign m_data      = m_data_r;
    assign m_last      = m_last_r;
    assign m_src       = m_src_r;
    assign busy        = (state_r == ST_LOCK);
    assign err_overlen = err_r;

endmodule

// File: tb/tb_yc_noc_arb.sv
// Directed table-driven bench for yc_noc_arb (N=4, W=32, MAX_FLITS=4).
// Inputs change 1ns after posedge; outputs are compared on the following negedge.
module tb_yc_noc_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int MF = 4;
    localparam int SW = 2;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   s_valid;
    logic [N*W-1:0] s_data;
    logic [N-1:0]   s_last;
    logic [N-1:0]   s_ready;
    logic           m_valid;
    logic [W-1:0]   m_data;
    logic           m_last;
    logic [SW-1:0]  m_src;
    logic           m_ready;
    logic           busy;
    logic           err_overlen;

    int n_vec  = 0;
    int n_fail = 0;

    yc_noc_arb #(.N(N), .W(W), .MAX_FLITS(MF)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_src(m_src),
        .m_ready(m_ready), .busy(busy), .err_overlen(err_overlen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  sv;
        logic [3:0]  sl;
        logic [15:0] tag;
        logic        mr;
        logic [3:0]  rdy;
        logic        mv;
        logic [15:0] etag;
        logic        ml;
        logic [1:0]  src;
        logic        bsy;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] mk(input logic [1:0] s, input logic [15:0] t);
        return {8'hA0 + {6'd0, s}, 8'h00, t};
    endfunction

    function void v(input logic rst, input logic [3:0] sv, input logic [3:0] sl,
                    input logic [15:0] tag, input logic mr, input logic [3:0] rdy,
                    input logic mv, input logic [15:0] etag, input logic ml,
                    input logic [1:0] src, input logic bsy, input logic err);
        vec_t t;
        t.rst = rst; t.sv = sv; t.sl = sl; t.tag = tag; t.mr = mr; t.rdy = rdy;
        t.mv = mv; t.etag = etag; t.ml = ml; t.src = src; t.bsy = bsy; t.err = err;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h expected %h", idx, nm, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] sv, input logic [3:0] sl,
                         input logic [15:0] tag, input logic mr);
        rst_n   = rst;
        s_valid = sv;
        s_last  = sl;
        m_ready = mr;
        for (int i = 0; i < N; i++) s_data[i*W +: W] = mk(2'(i), tag);
    endtask

    task automatic apply(input vec_t t, input int idx);
        @(posedge clk);
        #1;
        drive(t.rst, t.sv, t.sl, t.tag, t.mr);
        @(negedge clk);
        n_vec++;
        chk("s_ready", idx, 32'(s_ready), 32'(t.rdy));
        chk("m_valid", idx, 32'(m_valid), 32'(t.mv));
        chk("busy", idx, 32'(busy), 32'(t.bsy));
        chk("err_overlen", idx, 32'(err_overlen), 32'(t.err));
        if (t.mv) begin
            chk("m_data", idx, m_data, mk(t.src, t.etag));
            chk("m_last", idx, 32'(m_last), 32'(t.ml));
            chk("m_src", idx, 32'(m_src), 32'(t.src));
        end
    endtask

    initial begin
        drive(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b1);

        //   rst   sv       sl       tag       mr    rdy      mv    etag      ml    src   bsy   err
        // reset then idle
        v(1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        // src1 three-flit packet, then rr_ptr=2 picks src2 over src0
        v(1'b1, 4'b0010, 4'b0000, 16'h0011, 1'b1, 4'b0010, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0010, 4'b0000, 16'h0012, 1'b1, 4'b0010, 1'b1, 16'h0011, 1'b0, 2'd1, 1'b1, 1'b0);
        v(1'b1, 4'b0010, 4'b0010, 16'h0013, 1'b1, 4'b0010, 1'b1, 16'h0012, 1'b0, 2'd1, 1'b1, 1'b0);
        v(1'b1, 4'b0101, 4'b0101, 16'h0015, 1'b1, 4'b0100, 1'b1, 16'h0013, 1'b1, 2'd1, 1'b0, 1'b0);
        v(1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 16'h0015, 1'b1, 2'd2, 1'b0, 1'b0);
        v(1'b0, 4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        // src0 and src2 contend with 2-flit packets; no interleaving; wrap 3 -> 0
        v(1'b1, 4'b0101, 4'b0000, 16'h0021, 1'b1, 4'b0001, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0101, 4'b0101, 16'h0022, 1'b1, 4'b0001, 1'b1, 16'h0021, 1'b0, 2'd0, 1'b1, 1'b0);
        v(1'b1, 4'b0101, 4'b0000, 16'h0023, 1'b1, 4'b0100, 1'b1, 16'h0022, 1'b1, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0101, 4'b0101, 16'h0024, 1'b1, 4'b0100, 1'b1, 16'h0023, 1'b0, 2'd2, 1'b1, 1'b0);
        v(1'b1, 4'b1001, 4'b1001, 16'h0025, 1'b1, 4'b1000, 1'b1, 16'h0024, 1'b1, 2'd2, 1'b0, 1'b0);
        v(1'b1, 4'b0001, 4'b0001, 16'h0026, 1'b1, 4'b0001, 1'b1, 16'h0025, 1'b1, 2'd3, 1'b0, 1'b0);
        v(1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 16'h0026, 1'b1, 2'd0, 1'b0, 1'b0);
        // src3 locked with a 2-cycle valid gap while src0 waits
        v(1'b1, 4'b1000, 4'b0000, 16'h0031, 1'b1, 4'b1000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0001, 4'b0000, 16'h0099, 1'b1, 4'b0000, 1'b1, 16'h0031, 1'b0, 2'd3, 1'b1, 1'b0);
        v(1'b1, 4'b0001, 4'b0000, 16'h0099, 1'b1, 4'b0000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 1'b0);
        v(1'b1, 4'b1001, 4'b1000, 16'h0032, 1'b1, 4'b1000, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b1, 1'b0);
        v(1'b1, 4'b0011, 4'b0011, 16'h0033, 1'b1, 4'b0001, 1'b1, 16'h0032, 1'b1, 2'd3, 1'b0, 1'b0);
        // 4-cycle stall holds output, then drain + accept in one cycle
        v(1'b1, 4'b0010, 4'b0000, 16'h0041, 1'b0, 4'b0000, 1'b1, 16'h0033, 1'b1, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0010, 4'b0000, 16'h0041, 1'b0, 4'b0000, 1'b1, 16'h0033, 1'b1, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0010, 4'b0000, 16'h0041, 1'b0, 4'b0000, 1'b1, 16'h0033, 1'b1, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0010, 4'b0000, 16'h0041, 1'b0, 4'b0000, 1'b1, 16'h0033, 1'b1, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0010, 4'b0000, 16'h0041, 1'b1, 4'b0010, 1'b1, 16'h0033, 1'b1, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0010, 4'b0010, 16'h0042, 1'b1, 4'b0010, 1'b1, 16'h0041, 1'b0, 2'd1, 1'b1, 1'b0);
        v(1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 16'h0042, 1'b1, 2'd1, 1'b0, 1'b0);
        // src2 sends 6 flits, last on 6th: truncated at 4, sticky error
        v(1'b1, 4'b0100, 4'b0000, 16'h0051, 1'b1, 4'b0100, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0100, 4'b0000, 16'h0052, 1'b1, 4'b0100, 1'b1, 16'h0051, 1'b0, 2'd2, 1'b1, 1'b0);
        v(1'b1, 4'b0100, 4'b0000, 16'h0053, 1'b1, 4'b0100, 1'b1, 16'h0052, 1'b0, 2'd2, 1'b1, 1'b0);
        v(1'b1, 4'b0100, 4'b0000, 16'h0054, 1'b1, 4'b0100, 1'b1, 16'h0053, 1'b0, 2'd2, 1'b1, 1'b0);
        v(1'b1, 4'b0100, 4'b0000, 16'h0055, 1'b1, 4'b0100, 1'b1, 16'h0054, 1'b1, 2'd2, 1'b0, 1'b1);
        v(1'b1, 4'b0100, 4'b0100, 16'h0056, 1'b1, 4'b0100, 1'b1, 16'h0055, 1'b0, 2'd2, 1'b1, 1'b1);
        v(1'b1, 4'b0101, 4'b0101, 16'h0057, 1'b1, 4'b0001, 1'b1, 16'h0056, 1'b1, 2'd2, 1'b0, 1'b1);
        // reset while locked with a held output flit
        v(1'b1, 4'b0010, 4'b0000, 16'h0061, 1'b1, 4'b0010, 1'b1, 16'h0057, 1'b1, 2'd0, 1'b0, 1'b1);
        v(1'b0, 4'b0010, 4'b0000, 16'h0062, 1'b0, 4'b0000, 1'b1, 16'h0061, 1'b0, 2'd1, 1'b1, 1'b1);
        v(1'b1, 4'b1101, 4'b1101, 16'h0063, 1'b1, 4'b0001, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        v(1'b1, 4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 16'h0063, 1'b1, 2'd0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Back-to-back stream from src3 at full rate: one flit per cycle, last on 4th.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            drive(1'b1, (k < 4) ? 4'b1000 : 4'b0000, (k == 3) ? 4'b1000 : 4'b0000,
                  16'h0071 + 16'(k), 1'b1);
            @(negedge clk);
            n_vec++;
            chk("hs_s_ready", 100 + k, 32'(s_ready), (k < 4) ? 32'h8 : 32'h0);
            chk("hs_busy", 100 + k, 32'(busy), (k >= 1 && k <= 3) ? 32'h1 : 32'h0);
            chk("hs_m_valid", 100 + k, 32'(m_valid), (k > 0) ? 32'h1 : 32'h0);
            if (k > 0) begin
                chk("hs_m_data", 100 + k, m_data, mk(2'd3, 16'h0070 + 16'(k)));
                chk("hs_m_last", 100 + k, 32'(m_last), (k == 4) ? 32'h1 : 32'h0);
                chk("hs_m_src", 100 + k, 32'(m_src), 32'h3);
            end
        end
        chk("hs_err_overlen", 105, 32'(err_overlen), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/yc_noc_arb.md
Name: yc_noc_arb

Overview:
- N-input packet-aware round-robin arbiter/mux that sits directly upstream of the NoC skid/FIFO stage and feeds its s_* port.
- Selects one source per packet, holds the grant until that packet's last flit, and presents the flits through a 1-entry registered output.
- Enforces a maximum packet length and flags any violation with a sticky error.

Parameters:
- N, 4: number of input ports; must be at least 2.
- W, 32: flit data width.
- MAX_FLITS, 16: maximum flits per packet; must be at least 1.
- SW, $clog2(N): source index width (localparam).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- s_valid  input  N  per-source flit valid
- s_data  input  N*W  per-source flit; source i occupies [i*W +: W]
- s_last  input  N  per-source last-flit-of-packet marker
- s_ready  output  N  per-source accept
- m_valid  output  1  output flit valid
- m_data  output  W  output flit
- m_last  output  1  output last marker
- m_src  output  SW  index of the source that produced the current output flit
- m_ready  input  1  downstream accept
- busy  output  1  high while in LOCK state
- err_overlen  output  1  sticky packet-length violation flag

Behaviour:
- Reset: sampled on posedge clk when rst_n=0.
  - Clears out_full, m_data, m_last, m_src, rr_ptr, owner, flit_cnt and err_overlen; state <= IDLE.
  - Consequently m_valid=0, busy=0, err_overlen=0 after reset.
  - Reset mid-packet drops the lock and any held output flit. No partial-packet recovery.
- Output register:
  - out_acc = !out_full || m_ready.
  - m_valid = out_full.
  - m_data, m_last and m_src are register outputs and stay stable while m_valid && !m_ready.
- Grant:
  - IDLE: grant = first i in cyclic order rr_ptr, rr_ptr+1, ..., wrapping at N-1 -> 0, with s_valid[i]=1.
  - LOCK: grant = owner, regardless of the other valids.
  - s_ready[i] = out_acc && grant valid && (i == grant).
  - s_ready never depends on s_ready or on m_valid of another source.
  - At most one s_ready bit is high per cycle.
- Accept (s_valid[g] && s_ready[g]):
  - Output register loads s_data[g], m_src=g, and m_last = s_last[g] || force.
  - force = (flit_cnt == MAX_FLITS-1) && !s_last[g].
  - Latency from input accept to m_valid is 1 cycle.
  - Full throughput: 1 flit/cycle when m_ready is held high.
- Output register state update:
  - Accept and no drain: out_full <= 1.
  - Drain (m_valid && m_ready) and no accept: out_full <= 0.
  - Accept and drain in the same cycle: reload; out_full stays 1.
- FSM, IDLE:
  - Accepted flit with effective last: stay IDLE; rr_ptr <= (g+1) mod N; flit_cnt <= 0.
  - Accepted flit without effective last: -> LOCK; owner <= g; flit_cnt <= 1.
- FSM, LOCK:
  - Accepted flit with effective last: -> IDLE; rr_ptr <= (owner+1) mod N; flit_cnt <= 0.
  - Accepted flit without effective last: flit_cnt++.
  - Owner s_valid=0: hold LOCK; no other source is granted.
- Effective last = s_last || force.
  - On force: err_overlen <= 1 (sticky until reset), and the packet is truncated at MAX_FLITS flits.
  - Later flits from the same source start a new packet; that source is not favoured in arbitration.
- flit_cnt:
  - Width $clog2(MAX_FLITS+1).
  - Never exceeds MAX_FLITS-1 at the start of an accept.
  - MAX_FLITS=1 forces every flit to be last.
- Wrap-around: rr_ptr = N-1 followed by a grant to N-1 sets rr_ptr to 0.
- No valid, or out_acc=0: no state change, all s_ready=0.

Test Plan:
- Reset then idle -> m_valid=0, s_ready=0000, busy=0, err_overlen=0.
- Src1 sends 3 flits A1,A2,A3 (last on A3), m_ready=1 -> m_data A1,A2,A3 on consecutive cycles, each 1 cycle after accept, m_src=1, m_last only on A3; busy=1 during A2..A3 accepts; rr_ptr=2 afterwards.
- Src0 and src2 both send 2-flit packets from reset -> src0 packet complete (m_src=0,0), then src2 (2,2), no interleaving; then src0 again wins only after rr_ptr wraps past 3.
- LOCK on src3 with the s_valid[3] gap for 2 cycles while src0 is valid -> s_ready[0]=0 throughout; src3 resumes and completes; rr_ptr=0.
- m_ready=0 for 4 cycles with m_valid=1 -> m_data/m_last/m_src held stable, s_ready=0; m_ready=1 with a new accept in the same cycle -> m_valid stays 1 and new data appears next cycle.
- MAX_FLITS=4, src2 sends 6 flits with last only on the 6th -> 4th flit output with m_last=1, err_overlen=1 and stays 1; flits 5-6 form a second packet.
- Reset asserted in LOCK with m_valid=1 -> next cycle m_valid=0, busy=0, and arbitration restarts from src0.
